// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the UART_RX byte stream into SYNC/LEN/payload/CSUM packets and buffers each payload.
// Verified payloads drain over valid/ready; bad-length, bad-checksum and timed-out packets are dropped.
module uart_rx_pkt_ctrl #(
   parameter int          MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 104_160
) (
   input  logic       uart_clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [1:0] err_code,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam int             LW        = $clog2(MAX_LEN + 1);
   localparam int             GW        = $clog2(TIMEOUT_CYCLES);
   localparam int             DEPTH     = 1 << LW;
   localparam logic [GW-1:0]  GAP_MAX   = GW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [LW-1:0]  ONE       = LW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    csum_q, csum_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic          pkt_ok_q, pkt_ok_d;
   logic          pkt_err_q, pkt_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [7:0]    drop_q, drop_d;

   logic [7:0]    mem_q [DEPTH];
   logic          mem_we;
   logic [LW-1:0] wr_nxt, rd_nxt;
   logic          gap_expired;

   always_ff @(posedge uart_clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         csum_q     <= '0;
         gap_q      <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         pkt_ok_q   <= 1'b0;
         pkt_err_q  <= 1'b0;
         err_code_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         csum_q     <= csum_d;
         gap_q      <= gap_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         pkt_ok_q   <= pkt_ok_d;
         pkt_err_q  <= pkt_err_d;
         err_code_q <= err_code_d;
         drop_q     <= drop_d;
      end
   end

   // Payload storage needs no reset: it is only read after a full packet has been written.
   always_ff @(posedge uart_clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= rx_byte;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      csum_d      = csum_q;
      gap_d       = gap_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      pkt_ok_d    = 1'b0;
      pkt_err_d   = 1'b0;
      err_code_d  = err_code_q;
      drop_d      = drop_q;
      mem_we      = 1'b0;
      wr_nxt      = wr_ptr_q + ONE;
      rd_nxt      = rd_ptr_q + ONE;
      gap_expired = (gap_q == GAP_MAX) && !rx_done;

      case (state_q)
         S_IDLE: begin
            gap_d = '0;
            if (rx_done && (rx_byte == SYNC_BYTE)) begin
               state_d = S_LEN;
            end
         end

         S_DRAIN: begin
            gap_d = '0;
            if (rx_done && (drop_q != 8'hFF)) begin
               drop_d = drop_q + 8'd1;
            end
            if (m_valid_q && m_ready) begin
               if (m_last_q) begin
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  rd_ptr_d = rd_nxt;
                  m_data_d = mem_q[rd_nxt];
                  m_last_d = (rd_nxt == (len_q - ONE));
               end
            end
         end

         default: begin
            // LEN, PAYLOAD and CSUM share the inter-byte watchdog; a byte in the expiry cycle wins.
            gap_d = rx_done ? '0 : gap_q + 1'b1;
            if (gap_expired) begin
               pkt_err_d  = 1'b1;
               err_code_d = 2'd3;
               gap_d      = '0;
               state_d    = S_IDLE;
            end else if (rx_done) begin
               if (state_q == S_LEN) begin
                  if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
                     pkt_err_d  = 1'b1;
                     err_code_d = 2'd1;
                     state_d    = S_IDLE;
                  end else begin
                     len_d    = rx_byte[LW-1:0];
                     csum_d   = rx_byte;
                     wr_ptr_d = '0;
                     state_d  = S_PAYLOAD;
                  end
               end else if (state_q == S_PAYLOAD) begin
                  mem_we   = 1'b1;
                  csum_d   = csum_q ^ rx_byte;
                  wr_ptr_d = wr_nxt;
                  if (wr_nxt == len_q) begin
                     state_d = S_CSUM;
                  end
               end else begin
                  if (rx_byte == csum_q) begin
                     pkt_ok_d  = 1'b1;
                     rd_ptr_d  = '0;
                     m_valid_d = 1'b1;
                     m_data_d  = mem_q[0];
                     m_last_d  = (len_q == ONE);
                     state_d   = S_DRAIN;
                  end else begin
                     pkt_err_d  = 1'b1;
                     err_code_d = 2'd2;
                     state_d    = S_IDLE;
                  end
               end
            end
         end
      endcase
   end

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign pkt_ok   = pkt_ok_q;
   assign pkt_err  = pkt_err_q;
   assign err_code = err_code_q;
   assign busy     = (state_q != S_IDLE);
   assign drop_cnt = drop_q;

endmodule
